// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed register memory.
// Registered outputs, programmable wait states, PSLVERR on misaligned or
// out-of-window addresses. Only PSEL[SLV_IDX] selects this slave.
module apb_mem_slave #(
  parameter int          SLV_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  PSEL,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            write_q, write_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            ready_d, slverr_d;
  logic [31:0]     rdata_d;
  logic            mem_we;
  logic [31:0]     mem [DEPTH];

  // Address decode of the live bus, used only on the setup edge.
  logic          sel;
  logic [31:0]   off;
  logic          err_in;
  logic [AW-1:0] idx_in;
  logic          unused_psel;

  assign sel         = PSEL[SLV_IDX];
  assign off         = PADDR - BASE_ADDR;
  assign err_in      = (PADDR < BASE_ADDR) | (off >= SPAN) | (PADDR[1:0] != 2'b00);
  assign idx_in      = off[AW+1:2];
  assign unused_psel = ^PSEL;

  // Next-state, latched request fields and next registered outputs.
  // NOTE: every target gets a default before the case so no path can leave
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = '0;
    mem_we   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // PENABLE=1 without a preceding setup is simply ignored here.
        if (sel && !PENABLE) begin
          idx_d   = idx_in;
          write_d = PWRITE;
          wdata_d = PWDATA;
          err_d   = err_in;
          if (WAIT_CYCLES == 0) begin
            state_d  = S_RESP;
            ready_d  = 1'b1;
            slverr_d = err_in;
            rdata_d  = (!PWRITE && !err_in) ? mem[idx_in] : '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end

      S_WAIT: begin
        if (!sel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = S_RESP;
            ready_d  = 1'b1;
            slverr_d = err_q;
            rdata_d  = (!write_q && !err_q) ? mem[idx_q] : '0;
          end
        end
      end

      S_RESP: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (PENABLE) begin
          // Completion edge: commit a clean write, then drop the outputs.
          mem_we  = write_q & ~err_q;
          state_d = S_IDLE;
        end else begin
          ready_d  = PREADY;
          slverr_d = PSLVERR;
          rdata_d  = PRDATA;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, latched request and registered bus outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      PREADY  <= ready_d;
      PSLVERR <= slverr_d;
      PRDATA  <= rdata_d;
    end
  end

  // Word storage, written only on a clean write completion.
  // NOTE: the memory is cleared by reset because reads after reset must
  // return 0; this forces flops rather than a RAM macro, which is fine at
  // these depths.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB completer that terminates one select line of the bridge's APB bus in a word-addressed register memory. It has programmable wait states, drives PREADY, and flags PSLVERR on bad addresses. It is the responder end of the APB bus that the AHB-to-APB bridge drives, and it serves as the bridge's target in block- and system-level benches.

## Interface
- SLV_IDX, 0: index of the PSEL bit that selects this slave (0..2).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- DEPTH, 16: number of 32-bit words (power of two, 2..256).
- WAIT_CYCLES, 1: PREADY-low cycles inserted in each access phase (0..15).
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  3  one-hot slave selects; only PSEL[SLV_IDX] is used.
- PADDR  in  32  byte address.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  access-phase indicator.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid only while PREADY=1.
- PREADY  out  1  transfer-complete indicator.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- sel = PSEL[SLV_IDX]. The other PSEL bits are ignored.
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE:
  - On an edge with sel=1 and PENABLE=0 (setup), latch PADDR, PWRITE and PWDATA, and evaluate the error condition.
  - If WAIT_CYCLES=0, go to RESP. Otherwise load cnt=WAIT_CYCLES and go to WAIT.
- WAIT:
  - PREADY=0.
  - cnt decrements by 1 each edge. When cnt==1 at an edge, go to RESP.
- RESP:
  - PREADY=1. PSLVERR=err.
  - PRDATA = mem[idx] on a read without error, 0 otherwise.
  - The completion edge is the first edge in RESP with sel=1 and PENABLE=1.
  - At the completion edge, a write without error commits PWDATA to mem[idx], then the block returns to IDLE behaviour. If that same edge shows sel=1 and PENABLE=0, it is a new setup and is accepted immediately (back-to-back).
- Address decode:
  - off = PADDR - BASE_ADDR, 32-bit unsigned.
  - idx = off[log2(DEPTH)+1:2].
  - err = (PADDR < BASE_ADDR) | (off >= 4*DEPTH) | (PADDR[1:0] != 0).
- Errored writes never modify memory. Errored reads return PRDATA=0.
- Protocol faults:
  - sel drops in WAIT or RESP: abort to IDLE, no write, outputs return to 0 on the next edge.
  - PENABLE=1 seen in IDLE without a prior setup: ignored.
  - PWDATA, PADDR or PWRITE changing after setup: ignored, because the latched values are used.
- Reset (asynchronous, any state): state=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0, every mem word=0. Reset in the middle of a transfer loses that transfer.

## Timing
- Edge E0 samples setup. The first access cycle follows E0.
- PREADY rises WAIT_CYCLES cycles after the first access cycle and stays high until the completion edge.
  - WAIT_CYCLES=0: PREADY=1 in the first access cycle. A 2-cycle transfer with no waits.
  - General case: the transfer takes 2+WAIT_CYCLES cycles.
- PREADY, PSLVERR and PRDATA all drop to 0 in the cycle after completion, unless a back-to-back setup was accepted on the completion edge. In that case they are still 0 in that cycle, because the new transfer starts in WAIT or RESP.
- PRDATA and PSLVERR are 0 whenever PREADY=0.
- A write is visible to a read whose setup is on the completion edge itself.

## Test plan
- Reset, then read address 0x08 with BASE_ADDR=0 and WAIT_CYCLES=1 -> PREADY high in the 2nd access cycle, PRDATA=0, PSLVERR=0.
- Write 0xDEAD_BEEF to 0x0C, then read 0x0C back-to-back with WAIT_CYCLES=0 -> each transfer takes 2 cycles, read returns 0xDEAD_BEEF, PSLVERR=0.
- Write 0x1234_5678 to 0x40 with DEPTH=16 (out of range), then read 0x00..0x3C -> write completes with PSLVERR=1, every read returns 0.
- Access an unaligned 0x06 and an address below BASE_ADDR (BASE_ADDR=0x100, PADDR=0xFC) -> PSLVERR=1, PRDATA=0, memory unchanged.
- With WAIT_CYCLES=3, drop PSEL after 2 wait cycles of a write to 0x04 -> no PREADY, read of 0x04 still returns the old value.
- Assert HRESETn low in the middle of WAIT after writing 0xA5A5_A5A5 to 0x00 -> outputs go to 0 immediately, and a later read of 0x00 returns 0.
- Drive PSEL bit ≠ SLV_IDX with a full write sequence -> PREADY stays 0, memory unchanged.
